// File: rtl/ysyx_24080018_lsu_pkg.sv
// Shared types and constants for the ysyx_24080018 load/store unit.
// Covers FSM state codes, fun3 width/sign encodings, writeback error codes and access checks.
package ysyx_24080018_lsu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [2:0] FUN3_B  = 3'b000;
  localparam logic [2:0] FUN3_H  = 3'b001;
  localparam logic [2:0] FUN3_W  = 3'b010;
  localparam logic [2:0] FUN3_BU = 3'b100;
  localparam logic [2:0] FUN3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUN3     = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsuErr_e;

  function automatic logic fun3Illegal(input logic [2:0] fun3);
    return (fun3 == 3'b011) || (fun3 == 3'b110) || (fun3 == 3'b111);
  endfunction

  // fun3[1:0] selects access size; byte accesses can never be misaligned.
  function automatic logic isMisaligned(input logic [2:0] fun3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (fun3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_24080018_lsu_align.sv
// Combinational lane logic: replicates/masks store data into the addressed byte lanes
// and extracts plus sign/zero-extends load data from the returned word.
module ysyx_24080018_lsu_align
  import ysyx_24080018_lsu_pkg::*;
(
  input  logic [2:0]  fun3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] shifted;

  always_comb begin
    wmask_o = 4'b0000;
    wdata_o = 32'h0;
    case (fun3_i[1:0])
      2'b00: begin
        wmask_o = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      2'b01: begin
        wmask_o = 4'b0011 << off_i;
        wdata_o = {2{sdata_i[15:0]}};
      end
      2'b10: begin
        wmask_o = 4'b1111;
        wdata_o = sdata_i;
      end
      default: begin
        wmask_o = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

  // The addressed byte/half is brought down to bit 0 before extension.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    ldata_o = 32'h0;
    case (fun3_i)
      FUN3_B:  ldata_o = {{24{shifted[7]}}, shifted[7:0]};
      FUN3_H:  ldata_o = {{16{shifted[15]}}, shifted[15:0]};
      FUN3_W:  ldata_o = shifted;
      FUN3_BU: ldata_o = {24'h0, shifted[7:0]};
      FUN3_HU: ldata_o = {16'h0, shifted[15:0]};
      default: ldata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_24080018_lsu.sv
// Load/store unit behind the EXU: one outstanding memory access per op over a
// valid/ready request bus, with a bounded wait for the response and a valid/ready writeback record.
module ysyx_24080018_lsu
  import ysyx_24080018_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_fun3,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_wen,
  output logic [1:0]  out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [2:0]    fun3_q, fun3_d;
  logic          isLoad_q, isLoad_d;
  logic          isStore_q, isStore_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   outData_q, outData_d;
  logic          outWen_q, outWen_d;
  lsuErr_e       outErr_q, outErr_d;

  logic [3:0]  alignMask;
  logic [31:0] alignWdata;
  logic [31:0] loadData;

  ysyx_24080018_lsu_align u_align (
    .fun3_i  (fun3_q),
    .off_i   (addr_q[1:0]),
    .sdata_i (sdata_q),
    .rdata_i (mem_rsp_rdata),
    .wmask_o (alignMask),
    .wdata_o (alignWdata),
    .ldata_o (loadData)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    fun3_d    = fun3_q;
    isLoad_d  = isLoad_q;
    isStore_d = isStore_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    outData_d = outData_q;
    outWen_d  = outWen_q;
    outErr_d  = outErr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d    = in_result;
          sdata_d   = in_wdata;
          fun3_d    = in_fun3;
          isLoad_d  = in_is_load;
          isStore_d = in_is_store & ~in_is_load;
          rd_d      = in_rd;
          cnt_d     = '0;
          // Rejected ops go straight to writeback without touching memory.
          if (!(in_is_load || in_is_store)) begin
            state_d   = S_OUT;
            outData_d = in_result;
            outWen_d  = (in_rd != 5'd0);
            outErr_d  = ERR_OK;
          end else if (fun3Illegal(in_fun3)) begin
            state_d   = S_OUT;
            outData_d = 32'h0;
            outWen_d  = 1'b0;
            outErr_d  = ERR_FUN3;
          end else if (isMisaligned(in_fun3, in_result[1:0])) begin
            state_d   = S_OUT;
            outData_d = 32'h0;
            outWen_d  = 1'b0;
            outErr_d  = ERR_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response arriving on the final counted cycle still beats the timeout.
        if (mem_rsp_valid) begin
          state_d   = S_OUT;
          outData_d = isLoad_q ? loadData : 32'h0;
          outWen_d  = isLoad_q && (rd_q != 5'd0);
          outErr_d  = ERR_OK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_OUT;
          outData_d = 32'h0;
          outWen_d  = 1'b0;
          outErr_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      fun3_q    <= 3'b000;
      isLoad_q  <= 1'b0;
      isStore_q <= 1'b0;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      outData_q <= 32'h0;
      outWen_q  <= 1'b0;
      outErr_q  <= ERR_OK;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      fun3_q    <= fun3_d;
      isLoad_q  <= isLoad_d;
      isStore_q <= isStore_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      outData_q <= outData_d;
      outWen_q  <= outWen_d;
      outErr_q  <= outErr_d;
    end
  end

  // Request fields are forced to zero whenever no request is being offered.
  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_req_wen   = mem_req_valid & isStore_q;
  assign mem_req_wdata = mem_req_wen ? alignWdata : 32'h0;
  assign mem_req_wmask = mem_req_wen ? alignMask : 4'b0000;
  assign out_valid     = (state_q == S_OUT);
  assign out_rd        = rd_q;
  assign out_data      = outData_q;
  assign out_wen       = outWen_q;
  assign out_err       = outErr_q;

endmodule
